// File: rtl/if_id_fetch_stage_pkg.sv
// Shared MIPS front-end definitions: opcodes, the NOP word and the fetch FSM encoding.
package if_id_fetch_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  // sll $0,$0,0
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_id_fetch_stage_if.sv
// Ready-handshaked instruction-memory port between the fetch stage (master) and memory (slave).
interface if_id_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/if_id_fetch_stage_skid_buf.sv
// One-entry {instr, pc_plus4} skid buffer; clear (redirect) dominates load and drain.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        drain_i,
  input  logic        clear_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_plus4_i,
  output logic        full_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o
);

  logic        full_q, full_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;

  always_comb begin
    full_d  = full_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (clear_i) begin
      full_d = 1'b0;
    end else if (load_i) begin
      full_d  = 1'b1;
      instr_d = instr_i;
      pc4_d   = pc_plus4_i;
    end else if (drain_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      instr_q <= 32'h0;
      pc4_q   <= 32'h0;
    end else begin
      full_q  <= full_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  assign full_o     = full_q;
  assign instr_o    = instr_q;
  assign pc_plus4_o = pc4_q;

endmodule

// File: rtl/if_id_fetch_stage.sv
// Instruction fetch + IF/ID register with skid buffer and redirect handling.
// Optional MIPS_DELAY_SLOT_EN: on redirect, the word in flight or in the skid buffer becomes the delay slot.
module if_id_fetch_stage
  import if_id_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic                       clk,
  input  logic                       rst_n,
  if_id_fetch_stage_if.master        imem,
  input  logic                       stall_i,
  input  logic                       redirect_i,
  input  logic [31:0]                redirect_pc_i,
  output logic                       if_id_valid_o,
  output logic [31:0]                if_id_instr_o,
  output logic [5:0]                 if_id_opcode_o,
  output logic [31:0]                if_id_pc_plus4_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         valid_q, valid_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc4_q, pc4_d;
  logic         skid_load, skid_drain, skid_clear, skid_full;
  logic [31:0]  skid_instr, skid_pc4;
  logic [31:0]  pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  fetch_skid_buf u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (skid_load),
    .drain_i   (skid_drain),
    .clear_i   (skid_clear),
    .instr_i   (imem.imem_rdata),
    .pc_plus4_i(pc_plus4),
    .full_o    (skid_full),
    .instr_o   (skid_instr),
    .pc_plus4_o(skid_pc4)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc4_d      = pc4_q;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    skid_clear = 1'b0;

    unique case (state_q)
      ST_BOOT: state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem.imem_ready && !stall_i) begin
          valid_d = 1'b1;
          instr_d = imem.imem_rdata;
          pc4_d   = pc_plus4;
          pc_d    = pc_plus4;
        end else if (imem.imem_ready) begin
          skid_load = 1'b1;
          pc_d      = pc_plus4;
          state_d   = ST_HOLD;
        end else if (!stall_i) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end
      end
      ST_HOLD: begin
        if (!stall_i) begin
          valid_d    = skid_full;
          instr_d    = skid_full ? skid_instr : NOP_INSTR;
          pc4_d      = skid_pc4;
          skid_drain = 1'b1;
          state_d    = ST_FETCH;
        end
      end
      default: state_d = ST_BOOT;
    endcase

    // Redirect beats stall and any in-flight data, but BOOT ignores it.
    if (redirect_i && state_q != ST_BOOT) begin
      pc_d       = word_align(redirect_pc_i);
      skid_load  = 1'b0;
      skid_clear = 1'b1;
      state_d    = ST_FETCH;
`ifdef MIPS_DELAY_SLOT_EN
      if (state_q == ST_FETCH && imem.imem_ready) begin
        valid_d = 1'b1;
        instr_d = imem.imem_rdata;
        pc4_d   = pc_plus4;
      end else if (state_q == ST_HOLD && skid_full) begin
        valid_d = 1'b1;
        instr_d = skid_instr;
        pc4_d   = skid_pc4;
      end else begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end
`else
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= word_align(RESET_PC);
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  assign imem.imem_req  = (state_q == ST_FETCH);
  assign imem.imem_addr = pc_q;

  assign if_id_valid_o    = valid_q;
  assign if_id_instr_o    = instr_q;
  assign if_id_opcode_o   = instr_q[31:26];
  assign if_id_pc_plus4_o = pc4_q;

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Directed self-checking bench for if_id_fetch_stage; honours MIPS_DELAY_SLOT_EN when defined.
module tb_if_id_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        if_id_valid_o;
  logic [31:0] if_id_instr_o;
  logic [5:0]  if_id_opcode_o;
  logic [31:0] if_id_pc_plus4_o;

  int total = 0;
  int bad   = 0;

  logic        override_en   = 1'b0;
  logic [31:0] override_word = 32'h0;

  if_id_fetch_stage_if imem ();

  if_id_fetch_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem            (imem),
    .stall_i         (stall_i),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i),
    .if_id_valid_o   (if_id_valid_o),
    .if_id_instr_o   (if_id_instr_o),
    .if_id_opcode_o  (if_id_opcode_o),
    .if_id_pc_plus4_o(if_id_pc_plus4_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // addi-style word tagged with the low address bits so each fetch is distinguishable
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h2000_0000 | (a & 32'h0000_FFFF);
  endfunction

  task automatic cyc();
    imem.imem_rdata = override_en ? override_word : mem_word(imem.imem_addr);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    imem.imem_ready = 1'b1; imem.imem_rdata = 32'h0;
    @(negedge clk);
    total++; if (if_id_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", if_id_valid_o); end
    total++; if (if_id_instr_o !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=00000000", if_id_instr_o); end
    total++; if (if_id_pc_plus4_o !== 32'h0) begin bad++; $display("FAIL rst_pc4 got=%h exp=00000000", if_id_pc_plus4_o); end
    total++; if (imem.imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0b exp=0", imem.imem_req); end
    rst_n = 1'b1;
    #1;
    total++; if (imem.imem_req !== 1'b0) begin bad++; $display("FAIL boot_req got=%0b exp=0", imem.imem_req); end
    @(negedge clk);
  endtask

  task automatic test_stream();
    // the last negedge above already followed the BOOT edge
    total++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h0) begin
      bad++; $display("FAIL first_fetch req=%0b addr=%h exp req=1 addr=00000000", imem.imem_req, imem.imem_addr); end
    total++; if (if_id_valid_o !== 1'b0) begin bad++; $display("FAIL first_valid got=%0b exp=0", if_id_valid_o); end
    for (int i = 0; i < 3; i++) begin
      logic [31:0] a;
      logic [31:0] w;
      a = 32'(4 * i);
      w = mem_word(a);
      cyc();
      total++; if (if_id_valid_o !== 1'b1 || if_id_instr_o !== w || if_id_opcode_o !== w[31:26]) begin
        bad++; $display("FAIL stream_ifid i=%0d valid=%0b instr=%h op=%b exp instr=%h", i, if_id_valid_o, if_id_instr_o, if_id_opcode_o, w); end
      total++; if (if_id_pc_plus4_o !== a + 32'd4 || imem.imem_addr !== a + 32'd4) begin
        bad++; $display("FAIL stream_pc i=%0d pc4=%h addr=%h exp=%h", i, if_id_pc_plus4_o, imem.imem_addr, a + 32'd4); end
    end
  endtask

  task automatic test_stall_hold();
    stall_i = 1'b1; override_en = 1'b1; override_word = 32'h8C22_0004;
    cyc();
    override_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) cyc();
      total++; if (imem.imem_req !== 1'b0) begin bad++; $display("FAIL hold_req i=%0d got=%0b exp=0", i, imem.imem_req); end
      total++; if (if_id_instr_o !== mem_word(32'd8) || if_id_pc_plus4_o !== 32'd12 || if_id_valid_o !== 1'b1) begin
        bad++; $display("FAIL hold_frozen i=%0d instr=%h pc4=%h exp instr=%h pc4=0000000c", i, if_id_instr_o, if_id_pc_plus4_o, mem_word(32'd8)); end
    end
    stall_i = 1'b0;
    cyc();
    total++; if (if_id_instr_o !== 32'h8C22_0004 || if_id_opcode_o !== 6'b100011 || if_id_pc_plus4_o !== 32'd16 || if_id_valid_o !== 1'b1) begin
      bad++; $display("FAIL skid_release instr=%h op=%b pc4=%h exp instr=8c220004 op=100011 pc4=00000010", if_id_instr_o, if_id_opcode_o, if_id_pc_plus4_o); end
    total++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'd16) begin
      bad++; $display("FAIL resume_addr req=%0b addr=%h exp addr=00000010", imem.imem_req, imem.imem_addr); end
    cyc();
    total++; if (if_id_instr_o !== mem_word(32'd16) || if_id_pc_plus4_o !== 32'd20) begin
      bad++; $display("FAIL no_dup instr=%h pc4=%h exp instr=%h pc4=00000014", if_id_instr_o, if_id_pc_plus4_o, mem_word(32'd16)); end
  endtask

  task automatic test_not_ready();
    imem.imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      total++; if (if_id_valid_o !== 1'b0 || if_id_instr_o !== 32'h0) begin
        bad++; $display("FAIL bubble i=%0d valid=%0b instr=%h exp valid=0 instr=00000000", i, if_id_valid_o, if_id_instr_o); end
      total++; if (imem.imem_addr !== 32'd20 || imem.imem_req !== 1'b1) begin
        bad++; $display("FAIL bubble_addr i=%0d addr=%h exp=00000014", i, imem.imem_addr); end
    end
    imem.imem_ready = 1'b1;
    cyc();
    total++; if (if_id_valid_o !== 1'b1 || if_id_instr_o !== mem_word(32'd20) || if_id_pc_plus4_o !== 32'd24) begin
      bad++; $display("FAIL after_bubble instr=%h pc4=%h exp instr=%h pc4=00000018", if_id_instr_o, if_id_pc_plus4_o, mem_word(32'd20)); end
  endtask

  task automatic test_redirect_hold();
    stall_i = 1'b1;
    cyc();
    total++; if (imem.imem_req !== 1'b0) begin bad++; $display("FAIL redir_pre_hold req=%0b exp=0", imem.imem_req); end
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
    cyc();
    total++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h0000_0100) begin
      bad++; $display("FAIL redir_addr req=%0b addr=%h exp addr=00000100", imem.imem_req, imem.imem_addr); end
`ifdef MIPS_DELAY_SLOT_EN
    total++; if (if_id_valid_o !== 1'b1 || if_id_instr_o !== mem_word(32'd24) || if_id_pc_plus4_o !== 32'd28) begin
      bad++; $display("FAIL redir_delay_slot valid=%0b instr=%h pc4=%h exp instr=%h", if_id_valid_o, if_id_instr_o, if_id_pc_plus4_o, mem_word(32'd24)); end
`else
    total++; if (if_id_valid_o !== 1'b0 || if_id_instr_o !== 32'h0) begin
      bad++; $display("FAIL redir_flush valid=%0b instr=%h exp valid=0 instr=00000000", if_id_valid_o, if_id_instr_o); end
`endif
    redirect_i = 1'b0; stall_i = 1'b0;
    cyc();
    total++; if (if_id_valid_o !== 1'b1 || if_id_instr_o !== mem_word(32'h100) || if_id_pc_plus4_o !== 32'h104) begin
      bad++; $display("FAIL redir_target instr=%h pc4=%h exp instr=%h pc4=00000104", if_id_instr_o, if_id_pc_plus4_o, mem_word(32'h100)); end
  endtask

  task automatic test_wrap();
    imem.imem_ready = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    cyc();
    total++; if (imem.imem_addr !== 32'hFFFF_FFFC || if_id_valid_o !== 1'b0) begin
      bad++; $display("FAIL wrap_redir addr=%h valid=%0b exp addr=fffffffc valid=0", imem.imem_addr, if_id_valid_o); end
    redirect_i = 1'b0; imem.imem_ready = 1'b1;
    cyc();
    total++; if (if_id_valid_o !== 1'b1 || if_id_instr_o !== 32'h2000_FFFC || if_id_pc_plus4_o !== 32'h0) begin
      bad++; $display("FAIL wrap_ifid instr=%h pc4=%h exp instr=2000fffc pc4=00000000", if_id_instr_o, if_id_pc_plus4_o); end
    total++; if (imem.imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr got=%h exp=00000000", imem.imem_addr); end
  endtask

  task automatic test_reset_mid_hold();
    stall_i = 1'b1;
    cyc();
    total++; if (imem.imem_req !== 1'b0) begin bad++; $display("FAIL mid_hold_req got=%0b exp=0", imem.imem_req); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (if_id_valid_o !== 1'b0 || if_id_instr_o !== 32'h0 || if_id_pc_plus4_o !== 32'h0 || imem.imem_req !== 1'b0) begin
      bad++; $display("FAIL async_rst valid=%0b instr=%h pc4=%h req=%0b exp all 0", if_id_valid_o, if_id_instr_o, if_id_pc_plus4_o, imem.imem_req); end
    @(negedge clk);
    stall_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0040; rst_n = 1'b1;
    #1;
    total++; if (imem.imem_req !== 1'b0) begin bad++; $display("FAIL reboot_req got=%0b exp=0", imem.imem_req); end
    cyc();
    total++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h0) begin
      bad++; $display("FAIL boot_ignores_redir req=%0b addr=%h exp req=1 addr=00000000", imem.imem_req, imem.imem_addr); end
    redirect_i = 1'b0;
    cyc();
    total++; if (if_id_valid_o !== 1'b1 || if_id_instr_o !== mem_word(32'h0) || if_id_pc_plus4_o !== 32'd4) begin
      bad++; $display("FAIL restart_ifid instr=%h pc4=%h exp instr=%h pc4=00000004", if_id_instr_o, if_id_pc_plus4_o, mem_word(32'h0)); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_hold();
    test_not_ready();
    test_redirect_hold();
    test_wrap();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
